// File: rtl/write_ctrl_sync.sv
// Write-side controller for an async FIFO: write pointer, Gray pointer out, rptr synchroniser,
// registered full / fill level / almost-full, and a sticky overflow flag.
module write_ctrl_sync #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                rst_n,
  input  logic                signal_write,
  input  logic [ADDRSIZE:0]   graycode_rptr,
  input  logic [ADDRSIZE:0]   af_level,
  input  logic                ovf_clr,
  output logic                write_en,
  output logic [ADDRSIZE-1:0] write_address,
  output logic [ADDRSIZE:0]   graycode_wptr,
  output logic                full,
  output logic                almost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                overflow
);

  logic [SYNC_STAGES-1:0][ADDRSIZE:0] rsync_q, rsync_d;
  logic [ADDRSIZE:0] wcnt_q, wcnt_d;
  logic [ADDRSIZE:0] gwptr_q, gwptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;

  logic [ADDRSIZE:0] rq, rbin;
  logic              accept;

  assign rq = rsync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    rbin[ADDRSIZE] = rq[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) rbin[i] = rbin[i+1] ^ rq[i];
  end

  always_comb begin
    rsync_d  = {rsync_q[SYNC_STAGES-2:0], graycode_rptr};
    accept   = signal_write & ~full_q;
    wcnt_d   = wcnt_q + {{ADDRSIZE{1'b0}}, accept};
    gwptr_d  = wcnt_d ^ (wcnt_d >> 1);
    // Full when the next Gray pointer equals the synced read pointer with its top two bits inverted.
    full_d   = (gwptr_d == {~rq[ADDRSIZE:ADDRSIZE-1], rq[ADDRSIZE-2:0]});
    wlevel_d = wcnt_d - rbin;
    af_d     = (wlevel_d >= af_level);
    ovf_d    = (signal_write & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rsync_q  <= '0;
      wcnt_q   <= '0;
      gwptr_q  <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rsync_q  <= rsync_d;
      wcnt_q   <= wcnt_d;
      gwptr_q  <= gwptr_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign write_en      = signal_write & ~full_q;
  assign write_address = wcnt_q[ADDRSIZE-1:0];
  assign graycode_wptr = gwptr_q;
  assign full          = full_q;
  assign almost_full   = af_q;
  assign wlevel        = wlevel_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_write_ctrl_sync.sv
// Directed bench for write_ctrl_sync (ADDRSIZE=4, SYNC_STAGES=2).
module tb_write_ctrl_sync;
  localparam int A = 4;

  logic         wclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         signal_write = 1'b0;
  logic [A:0]   graycode_rptr = '0;
  logic [A:0]   af_level = '0;
  logic         ovf_clr = 1'b0;
  logic         write_en;
  logic [A-1:0] write_address;
  logic [A:0]   graycode_wptr;
  logic         full;
  logic         almost_full;
  logic [A:0]   wlevel;
  logic         overflow;

  int n_cmp = 0;
  int n_fail = 0;

  write_ctrl_sync #(.ADDRSIZE(A), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .rst_n(rst_n), .signal_write(signal_write), .graycode_rptr(graycode_rptr),
    .af_level(af_level), .ovf_clr(ovf_clr), .write_en(write_en), .write_address(write_address),
    .graycode_wptr(graycode_wptr), .full(full), .almost_full(almost_full), .wlevel(wlevel),
    .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge wclk);
    rst_n = 1'b0; signal_write = 1'b0; ovf_clr = 1'b0; graycode_rptr = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    af_level = '0;
    apply_reset();
    #1;
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", full); end
    n_cmp++; if (wlevel !== 5'd0) begin n_fail++; $display("FAIL reset_wlevel got %0d exp 0", wlevel); end
    n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %0b exp 0", almost_full); end
    n_cmp++; if (write_address !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", write_address); end
    n_cmp++; if (graycode_wptr !== 5'd0) begin n_fail++; $display("FAIL reset_gwptr got %0h exp 0", graycode_wptr); end
    step();
    n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_level0 got %0b exp 1", almost_full); end
  endtask

  task automatic test_fill();
    af_level = 5'd20;
    signal_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (write_address !== 4'(i)) begin n_fail++; $display("FAIL fill_addr[%0d] got %0d exp %0d", i, write_address, i); end
      n_cmp++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL fill_wen[%0d] got %0b exp 1", i, write_en); end
      step();
      n_cmp++; if (wlevel !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_wlevel[%0d] got %0d exp %0d", i, wlevel, i + 1); end
      n_cmp++; if (full !== (i == 15)) begin n_fail++; $display("FAIL fill_full[%0d] got %0b exp %0b", i, full, i == 15); end
      n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_hi[%0d] got %0b exp 0", i, almost_full); end
    end
    n_cmp++; if (graycode_wptr !== 5'b11000) begin n_fail++; $display("FAIL fill_gwptr got %b exp 11000", graycode_wptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d] got %0b exp 0", i, write_en); end
      n_cmp++; if (write_address !== 4'd0) begin n_fail++; $display("FAIL ovf_addr[%0d] got %0d exp 0", i, write_address); end
      step();
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set[%0d] got %0b exp 1", i, overflow); end
    end
    ovf_clr = 1'b1;
    step();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %0b exp 1", overflow); end
    signal_write = 1'b0;
    step();
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_read_advance();
    graycode_rptr = 5'b00001;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (full !== 1'b1 || wlevel !== 5'd16) begin n_fail++; $display("FAIL rd_lat[%0d] got full=%0b lvl=%0d exp 1/16", i, full, wlevel); end
    end
    step();
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rd_full got %0b exp 0", full); end
    n_cmp++; if (wlevel !== 5'd15) begin n_fail++; $display("FAIL rd_wlevel got %0d exp 15", wlevel); end
    signal_write = 1'b1;
    #1;
    n_cmp++; if (write_en !== 1'b1) begin n_fail++; $display("FAIL rd_wen got %0b exp 1", write_en); end
    step();
    signal_write = 1'b0;
    n_cmp++; if (full !== 1'b1 || wlevel !== 5'd16) begin n_fail++; $display("FAIL rd_refill got full=%0b lvl=%0d exp 1/16", full, wlevel); end
    n_cmp++; if (graycode_wptr !== 5'b11001) begin n_fail++; $display("FAIL rd_gwptr got %b exp 11001", graycode_wptr); end
  endtask

  task automatic test_almost_full();
    apply_reset();
    af_level = 5'd12;
    signal_write = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++; if (almost_full !== (i == 11)) begin n_fail++; $display("FAIL af_rise[%0d] got %0b exp %0b", i, almost_full, i == 11); end
    end
    signal_write = 1'b0;
    graycode_rptr = 5'b00001;
    step(); step();
    n_cmp++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_hold got %0b exp 1", almost_full); end
    step();
    n_cmp++; if (almost_full !== 1'b0 || wlevel !== 5'd11) begin n_fail++; $display("FAIL af_drop got af=%0b lvl=%0d exp 0/11", almost_full, wlevel); end
  endtask

  task automatic test_back_to_back();
    int wtot, rtot, cyc, occ;
    logic acc;
    logic [A:0] prev;
    logic [A:0] rb;
    apply_reset();
    af_level = 5'd20;
    wtot = 0; rtot = 0; cyc = 0;
    step();
    signal_write = 1'b1;
    while (wtot < 100 && cyc < 400) begin
      #1;
      acc = write_en;
      prev = graycode_wptr;
      if (acc) begin
        n_cmp++; if (write_address !== 4'(wtot)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %0d exp %0d", wtot, write_address, wtot % 16); end
      end
      step();
      cyc++;
      n_cmp++; if ($countones(prev ^ graycode_wptr) !== (acc ? 1 : 0)) begin n_fail++; $display("FAIL b2b_gray[%0d] got %b->%b", cyc, prev, graycode_wptr); end
      if (acc) wtot++;
      occ = wtot - rtot;
      n_cmp++; if (int'(wlevel) > 16 || int'(wlevel) < occ) begin n_fail++; $display("FAIL b2b_wlevel[%0d] got %0d exp %0d..16", cyc, wlevel, occ); end
      if (occ >= 4) begin
        rtot++;
        rb = 5'(rtot);
        graycode_rptr = rb ^ (rb >> 1);
      end
    end
    n_cmp++; if (wtot < 100) begin n_fail++; $display("FAIL b2b_timeout got %0d writes exp 100", wtot); end
    signal_write = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    af_level = 5'd20;
    signal_write = 1'b1;
    for (int i = 0; i < 17; i++) step();
    signal_write = 1'b0;
    graycode_rptr = 5'b00100;
    step(); step(); step();
    n_cmp++; if (wlevel !== 5'd9 || overflow !== 1'b1) begin n_fail++; $display("FAIL ar_pre got lvl=%0d ovf=%0b exp 9/1", wlevel, overflow); end
    signal_write = 1'b1;
    #2;
    rst_n = 1'b0; signal_write = 1'b0; graycode_rptr = '0;
    #1;
    n_cmp++; if ({wlevel, overflow, full, almost_full, graycode_wptr, write_address, write_en} !== '0) begin
      n_fail++; $display("FAIL ar_async got lvl=%0d ovf=%0b full=%0b af=%0b gw=%0h addr=%0d wen=%0b exp all 0",
                          wlevel, overflow, full, almost_full, graycode_wptr, write_address, write_en);
    end
    #2;
    rst_n = 1'b1;
    signal_write = 1'b1;
    #1;
    n_cmp++; if (write_address !== 4'd0 || write_en !== 1'b1) begin n_fail++; $display("FAIL ar_resume got addr=%0d wen=%0b exp 0/1", write_address, write_en); end
    step();
    n_cmp++; if (wlevel !== 5'd1 || graycode_wptr !== 5'd1) begin n_fail++; $display("FAIL ar_first got lvl=%0d gw=%0h exp 1/1", wlevel, graycode_wptr); end
    step();
    signal_write = 1'b0;
    n_cmp++; if (write_address !== 4'd2) begin n_fail++; $display("FAIL ar_addr got %0d exp 2", write_address); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_advance();
    test_almost_full();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
